dma_req_arbiter: RTL
====================

# dma_req_arbiter

Request arbiter that sits directly upstream of the shared-memory DMA engine. It collects copy requests from up to PROC_CNT processors, each with direction, shared-memory pointer, local start address and length. It serialises them round-robin and drives the DMA's toggle-trigger handshake. It returns a one-cycle acknowledge to the requesting processor when the DMA reports completion.

## Interface
- PROC_CNT, 4, number of requesting processors (≥2)
- TIMEOUT, 64, watchdog limit in cycles (used only with DMA_ARB_TIMEOUT_EN)
- clock  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- req[PROC_CNT]  in  1  level request per processor
- req_write[PROC_CNT]  in  1  direction: 0 = READ (shm→proc), 1 = WRITE (proc→shm)
- req_ptr[PROC_CNT]  in  SIZE  shared-memory word pointer
- req_start[PROC_CNT]  in  PROCSIZE  local memory start address
- req_length[PROC_CNT]  in  PROCSIZE  word count
- req_ack[PROC_CNT]  out  1  one-cycle completion pulse
- req_err[PROC_CNT]  out  1  one-cycle abort pulse, coincident with req_ack
- dma_trigger  out  1  toggles once per issued transfer
- dma_proc  out  $clog2(PROC_CNT)  index of the granted processor
- dma_action  out  1  latched req_write
- dma_ptr / dma_start / dma_length  out  SIZE / PROCSIZE / PROCSIZE  latched request fields
- dma_done  in  1  one-cycle completion pulse from the DMA
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Round-robin search starts at last_grant+1 mod PROC_CNT.
  - On the first asserted req, latch its index and fields into the dma_* registers.
  - Next state: ISSUE if length ≠ 0; otherwise ACK (zero-length requests never reach the DMA).
- ISSUE: invert dma_trigger, go to WAIT. dma_* fields stay stable until the following grant.
- WAIT: on dma_done, go to ACK. dma_done in any other state is ignored.
- ACK: pulse req_ack[granted] for one cycle, set last_grant = granted, return to IDLE.
- Requester duties:
  - Hold req and its fields stable until the grant edge. Fields may change afterwards.
  - Deassert req in the cycle after req_ack. A req still high then is treated as a new request.
- Reset (any state, including mid-WAIT):
  - Clears state to IDLE, last_grant to PROC_CNT-1, dma_trigger to 0, and all dma_* outputs, req_ack, req_err and busy to 0.
  - The DMA shares reset_n, so its trigger history matches.
  - A transfer in flight is dropped and not acknowledged.
- Width rules: index arithmetic wraps modulo PROC_CNT. The timeout counter is $clog2(TIMEOUT+1) bits and saturates.

## Timing
- req sampled high at edge N → ISSUE during N+1 with dma_* valid → dma_trigger toggled from edge N+2.
- dma_done high at edge M → req_ack high during cycle M+1 only.
- Zero-length request: req at edge N → req_ack during N+1, with no trigger toggle.
- Back-to-back: the next grant happens at the IDLE edge following ACK. Minimum spacing between triggers is 4 cycles.
- All outputs are registered, with no combinational path from req or dma_done to any output.

## Configuration
- DMA_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - After TIMEOUT cycles without dma_done, go to ACK and pulse req_ack and req_err together.
  - dma_done in the same cycle as expiry wins; req_err stays low.
- DMA_ARB_TIMEOUT_EN undefined: WAIT lasts indefinitely, req_err is tied to 0, and no counter is generated.

## Structure
- Shared package shm_pkg holds:
  - SIZE, PROCSIZE, PAGE_SIZE, WORD_SIZE constants
  - action enum (READ=0, WRITE=1)
  - arb_state_t enum
- Sub-module dma_rr_picker: combinational round-robin priority encoder. Inputs: req vector and last_grant. Outputs: valid and index.

## Test plan
- Single request: proc 2, READ, ptr=4'h5, start=3, len=4 → dma_trigger 0→1 two edges after req; dma_proc=2, dma_action=0, dma_ptr=5, dma_start=3, dma_length=4. dma_done pulse → req_ack[2] for exactly one cycle, with a 1-cycle delay.
- Contention: req 0, 1 and 3 held from reset → grants in order 0, 1, 3, then 0. Four trigger toggles, each ack on the matching index.
- Zero length: proc 1, len=0 → req_ack[1] one cycle after the grant edge; dma_trigger unchanged; busy high for 1 cycle.
- Reset in WAIT: reset_n low for 2 cycles → all outputs 0, no ack. After release, req 0 still high → reissued with dma_trigger 0→1.
- Timeout (DMA_ARB_TIMEOUT_EN, TIMEOUT=16): no dma_done → req_ack[g] and req_err[g] pulse after 16 WAIT cycles, then the next request is served. Without the macro, the block stays in WAIT and busy stays high.
- Spurious dma_done pulse in IDLE and in ISSUE → no ack, no state change.

Source files
------------

// File: rtl/shm_pkg.sv
// Shared constants and enums for the shared-memory DMA request path.
package shm_pkg;

   localparam int SIZE      = 8;
   localparam int PROCSIZE  = 8;
   localparam int PAGE_SIZE = 256;
   localparam int WORD_SIZE = 32;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } action_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/dma_req_arbiter_if.sv
// Request/DMA bundle between processors, the arbiter and the DMA engine.
interface dma_req_arbiter_if
   import shm_pkg::*;
#(
   parameter int PROC_CNT = 4
);
   localparam int IDX_W = $clog2(PROC_CNT);

   logic [PROC_CNT-1:0] req;
   logic [PROC_CNT-1:0] req_write;
   logic [SIZE-1:0]     req_ptr    [PROC_CNT];
   logic [PROCSIZE-1:0] req_start  [PROC_CNT];
   logic [PROCSIZE-1:0] req_length [PROC_CNT];
   logic [PROC_CNT-1:0] req_ack;
   logic [PROC_CNT-1:0] req_err;

   logic                dma_trigger;
   logic [IDX_W-1:0]    dma_proc;
   logic                dma_action;
   logic [SIZE-1:0]     dma_ptr;
   logic [PROCSIZE-1:0] dma_start;
   logic [PROCSIZE-1:0] dma_length;
   logic                dma_done;
   logic                busy;

   // slave = arbiter, master = requesters plus DMA engine
   modport slave (
      input  req, req_write, req_ptr, req_start, req_length, dma_done,
      output req_ack, req_err, dma_trigger, dma_proc, dma_action,
             dma_ptr, dma_start, dma_length, busy
   );

   modport master (
      output req, req_write, req_ptr, req_start, req_length, dma_done,
      input  req_ack, req_err, dma_trigger, dma_proc, dma_action,
             dma_ptr, dma_start, dma_length, busy
   );

endinterface

// File: rtl/dma_rr_picker.sv
// Combinational round-robin priority encoder; search starts at last_grant+1.
module dma_rr_picker #(
   parameter  int PROC_CNT = 4,
   localparam int IDX_W    = $clog2(PROC_CNT)
) (
   input  logic [PROC_CNT-1:0] req,
   input  logic [IDX_W-1:0]    last_grant,
   output logic                valid,
   output logic [IDX_W-1:0]    index
);

   int cand;

   // Walk from farthest to nearest so the nearest requester overwrites last.
   always_comb begin
      valid = 1'b0;
      index = '0;
      cand  = 0;
      for (int off = PROC_CNT; off >= 1; off--) begin
         cand = int'(last_grant) + off;
         if (cand >= PROC_CNT) cand = cand - PROC_CNT;
         if (req[IDX_W'(cand)]) begin
            valid = 1'b1;
            index = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/dma_req_arbiter.sv
// Round-robin DMA request arbiter with toggle-trigger handshake.
// Optional WAIT watchdog enabled by defining DMA_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | searching for next requester, fields latched on grant
// ISSUE | toggling dma_trigger towards the DMA
// WAIT  | transfer in flight, waiting for dma_done
// ACK   | req_ack (and req_err on timeout) pulsing to the granted proc
module dma_req_arbiter
   import shm_pkg::*;
#(
   parameter int PROC_CNT = 4,
   parameter int TIMEOUT  = 64
) (
   input logic              clock,
   input logic              reset_n,
   dma_req_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(PROC_CNT);

   if (PROC_CNT < 2 || TIMEOUT < 1) begin : g_param_check
      $error("dma_req_arbiter: PROC_CNT must be >= 2 and TIMEOUT >= 1");
   end

   arb_state_t       state;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] grant_q;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;

`ifdef DMA_ARB_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   logic [TMR_W-1:0] tmr;
`else
   assign bus.req_err = '0;
`endif

   dma_rr_picker #(.PROC_CNT(PROC_CNT)) u_picker (
      .req        (bus.req),
      .last_grant (last_grant),
      .valid      (pick_valid),
      .index      (pick_idx)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         last_grant      <= IDX_W'(PROC_CNT - 1);
         grant_q         <= '0;
         bus.req_ack     <= '0;
         bus.dma_trigger <= 1'b0;
         bus.dma_proc    <= '0;
         bus.dma_action  <= 1'b0;
         bus.dma_ptr     <= '0;
         bus.dma_start   <= '0;
         bus.dma_length  <= '0;
         bus.busy        <= 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
         bus.req_err     <= '0;
         tmr             <= '0;
`endif
      end else begin
         bus.req_ack <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
         bus.req_err <= '0;
`endif
         unique case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant_q        <= pick_idx;
                  bus.dma_proc   <= pick_idx;
                  bus.dma_action <= bus.req_write[pick_idx];
                  bus.dma_ptr    <= bus.req_ptr[pick_idx];
                  bus.dma_start  <= bus.req_start[pick_idx];
                  bus.dma_length <= bus.req_length[pick_idx];
                  bus.busy       <= 1'b1;
                  // zero-length requests complete without touching the DMA
                  if (bus.req_length[pick_idx] != '0) begin
                     state <= ISSUE;
                  end else begin
                     state                 <= ACK;
                     bus.req_ack[pick_idx] <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               bus.dma_trigger <= ~bus.dma_trigger;
               state           <= WAIT;
`ifdef DMA_ARB_TIMEOUT_EN
               tmr             <= TMR_W'(TIMEOUT - 1);
`endif
            end
            WAIT: begin
               if (bus.dma_done) begin
                  state                <= ACK;
                  bus.req_ack[grant_q] <= 1'b1;
               end
`ifdef DMA_ARB_TIMEOUT_EN
               else if (tmr == '0) begin
                  state                <= ACK;
                  bus.req_ack[grant_q] <= 1'b1;
                  bus.req_err[grant_q] <= 1'b1;
               end else begin
                  tmr <= tmr - 1'b1;
               end
`endif
            end
            ACK: begin
               last_grant <= grant_q;
               bus.busy   <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
